fetch_sequencer: RTL

Instruction-fetch controller that sequences the word-indexed instruction memory. It owns the program counter and drives the memory address each cycle. It captures the combinationally returned instruction into an output register and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects, back-pressure stalls and end-of-program detection, and sits between the instruction memory and the decode stage of the MIPS datapath.

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Types and widths shared by the MIPS datapath blocks.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the word-indexed PC, registers the fetched word
// and hands it to decode over valid/ready, with redirect, stall and end-of-program handling.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned     DEPTH    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               done,
  output logic [31:0]        issued_count
);

  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(DEPTH);

  fetch_state_e       r_state;
  logic [PC_W-1:0]    r_pc;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [PC_W-1:0]    r_out_pc;
  logic               r_done;
  logic [31:0]        r_issued_count;

  logic w_accept;
  logic w_pc_in_range;
  logic w_fetch_en;
  logic w_end;

  assign w_accept      = r_out_valid && out_ready;
  assign w_pc_in_range = r_pc < PC_LIMIT;
  assign w_fetch_en    = (!r_out_valid || out_ready) && w_pc_in_range;
  // Program is finished once the PC has left memory and nothing is left in the output slot.
  assign w_end         = !w_pc_in_range && (!r_out_valid || w_accept);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= FETCH_IDLE;
      r_pc           <= RESET_PC;
      r_out_valid    <= 1'b0;
      r_out_instr    <= '0;
      r_out_pc       <= '0;
      r_done         <= 1'b0;
      r_issued_count <= '0;
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          if (start) begin
            r_state        <= FETCH_RUN;
            r_pc           <= RESET_PC;
            r_issued_count <= '0;
          end
        end
        FETCH_RUN: begin
          // An accept in the redirect cycle still counts; only the not-yet-taken word is lost.
          if (w_accept) begin
            r_issued_count <= r_issued_count + 32'd1;
          end
          if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
          end else if (w_end) begin
            r_state     <= FETCH_DONE;
            r_done      <= 1'b1;
            r_out_valid <= 1'b0;
          end else if (w_fetch_en) begin
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
            r_pc        <= r_pc + 32'd1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        FETCH_DONE: begin
          if (start) begin
            r_state        <= FETCH_RUN;
            r_pc           <= RESET_PC;
            r_issued_count <= '0;
            r_done         <= 1'b0;
          end
        end
        default: begin
          r_state <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_pc       = r_out_pc;
  assign done         = r_done;
  assign issued_count = r_issued_count;

  a_done_no_valid: assert property (@(posedge clk) disable iff (!rst_n) r_done |-> !r_out_valid);

endmodule
